// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation and FSM state encodings, iteration bound and op decode helpers.
package muldiv_pkg;

   typedef logic [1:0] op_t;

   localparam op_t OP_MULT  = 2'b00;
   localparam op_t OP_MULTU = 2'b01;
   localparam op_t OP_DIV   = 2'b10;
   localparam op_t OP_DIVU  = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_FIXUP = 2'd3;

   localparam logic [4:0] ITER_LAST = 5'd31;

   function automatic logic isSignedOp(input op_t opCode);
      return ~opCode[0];
   endfunction

   function automatic logic isDivOp(input op_t opCode);
      return opCode[1];
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore the sign of products, quotients and remainders.
module muldiv_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_value,
   input  logic             i_negate,
   output logic [WIDTH-1:0] o_value
);

   assign o_value = i_negate ? ((~i_value) + WIDTH'(1)) : i_value;

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage multiply/divide controller: runs MULT/MULTU/DIV/DIVU over a shared
// 32-step shift-add / restoring shift-subtract datapath and owns HI/LO.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             rd_hilo,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   logic [1:0]         r_state;
   op_t                r_op;
   logic [WIDTH-1:0]   r_aRaw;
   logic [WIDTH-1:0]   r_bRaw;
   logic [WIDTH-1:0]   r_opA;
   logic [WIDTH-1:0]   r_opB;
   logic [2*WIDTH-1:0] r_acc;
   logic [4:0]         r_iter;
   logic               r_signA;
   logic               r_signB;
   logic               r_divZero;
   logic               r_done;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_isDiv;
   logic               w_isSigned;
   logic [WIDTH-1:0]   w_magA;
   logic [WIDTH-1:0]   w_magB;
   logic [WIDTH:0]     w_mulSum;
   logic [WIDTH:0]     w_remShift;
   logic               w_remGe;
   logic [WIDTH-1:0]   w_remSub;
   logic [WIDTH-1:0]   w_remNext;
   logic               w_resultNeg;
   logic [2*WIDTH-1:0] w_prodFixed;
   logic [WIDTH-1:0]   w_quoFixed;
   logic [WIDTH-1:0]   w_remFixed;

   assign w_isDiv    = isDivOp(r_op);
   assign w_isSigned = isSignedOp(r_op);

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_magA (
      .i_value  (r_aRaw),
      .i_negate (w_isSigned & r_aRaw[WIDTH-1]),
      .o_value  (w_magA)
   );

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_magB (
      .i_value  (r_bRaw),
      .i_negate (w_isSigned & r_bRaw[WIDTH-1]),
      .o_value  (w_magB)
   );

   // Multiply: the accumulator upper half gathers partial sums and the whole
   // accumulator shifts right, so after 32 steps it holds the full product.
   assign w_mulSum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_opB[0] ? {1'b0, r_opA} : '0);

   // Divide: accumulator upper half is the partial remainder, lower half
   // collects quotient bits; the dividend feeds in MSB-first from r_opA.
   assign w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_opA[WIDTH-1]};
   assign w_remGe    = (w_remShift >= {1'b0, r_opB});
   assign w_remSub   = w_remShift[WIDTH-1:0] - r_opB;
   assign w_remNext  = w_remGe ? w_remSub : w_remShift[WIDTH-1:0];

   assign w_resultNeg = r_signA ^ r_signB;

   muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_prodFix (
      .i_value  (r_acc),
      .i_negate (w_resultNeg),
      .o_value  (w_prodFixed)
   );

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_quoFix (
      .i_value  (r_acc[WIDTH-1:0]),
      .i_negate (w_resultNeg),
      .o_value  (w_quoFixed)
   );

   muldiv_sign_fix #(.WIDTH(WIDTH)) u_remFix (
      .i_value  (r_acc[2*WIDTH-1:WIDTH]),
      .i_negate (r_signA),
      .o_value  (w_remFixed)
   );

   // Sequencer FSM plus HI/LO; MTHI/MTLO and new ops are only taken in IDLE,
   // anything arriving while busy is held off by the stall output.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state   <= ST_IDLE;
         r_op      <= OP_MULT;
         r_aRaw    <= '0;
         r_bRaw    <= '0;
         r_opA     <= '0;
         r_opB     <= '0;
         r_acc     <= '0;
         r_iter    <= '0;
         r_signA   <= 1'b0;
         r_signB   <= 1'b0;
         r_divZero <= 1'b0;
         r_done    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (wr_hi) begin
                  r_hi <= wdata;
               end
               if (wr_lo) begin
                  r_lo <= wdata;
               end
               if (start) begin
                  r_op    <= op;
                  r_aRaw  <= a;
                  r_bRaw  <= b;
                  r_state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               r_signA   <= w_isSigned & r_aRaw[WIDTH-1];
               r_signB   <= w_isSigned & r_bRaw[WIDTH-1];
               r_opA     <= w_magA;
               r_opB     <= w_magB;
               r_acc     <= '0;
               r_iter    <= '0;
               r_divZero <= (r_bRaw == '0);
               r_state   <= ST_RUN;
            end
            ST_RUN: begin
               if (w_isDiv) begin
                  r_acc <= {w_remNext, r_acc[WIDTH-2:0], w_remGe};
                  r_opA <= r_opA << 1;
               end else begin
                  r_acc <= {w_mulSum, r_acc[WIDTH-1:1]};
                  r_opB <= r_opB >> 1;
               end
               if (r_iter == ITER_LAST) begin
                  r_state <= ST_FIXUP;
               end else begin
                  r_iter <= r_iter + 5'd1;
               end
            end
            ST_FIXUP: begin
               if (w_isDiv) begin
                  if (r_divZero) begin
                     r_hi <= r_aRaw;
                     r_lo <= '1;
                  end else begin
                     r_hi <= w_remFixed;
                     r_lo <= w_quoFixed;
                  end
               end else begin
                  r_hi <= w_prodFixed[2*WIDTH-1:WIDTH];
                  r_lo <= w_prodFixed[WIDTH-1:0];
               end
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign hi    = r_hi;
   assign lo    = r_lo;
   assign busy  = (r_state != ST_IDLE);
   assign done  = r_done;
   assign stall = busy & (start | rd_hilo | wr_hi | wr_lo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: a table of directed mul/div
// vectors followed by hand-written hazard, MTHI/MTLO and reset sequences.
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        rd_hilo;
   logic        wr_hi;
   logic        wr_lo;
   logic [31:0] wdata;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        stall;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expHi;
      logic [31:0] expLo;
   } vec_t;

   localparam int NUM_VECS = 14;
   vec_t vecs[NUM_VECS];

   muldiv_sequencer #(.WIDTH(32)) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .rd_hilo (rd_hilo),
      .wr_hi   (wr_hi),
      .wr_lo   (wr_lo),
      .wdata   (wdata),
      .hi      (hi),
      .lo      (lo),
      .busy    (busy),
      .done    (done),
      .stall   (stall)
   );

   always #5 Clk = ~Clk;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Presents one op in the next cycle and returns the cycle count to done.
   task automatic applyStimulus(input logic [1:0] opIn, input logic [31:0] aIn,
                                input logic [31:0] bIn, output int latency);
      @(negedge Clk);
      start = 1'b1;
      op    = opIn;
      a     = aIn;
      b     = bIn;
      latency = 0;
      while (latency < 100) begin
         @(negedge Clk);
         latency++;
         start = 1'b0;
         if (done) break;
      end
   endtask

   initial begin
      int lat;
      int errs;
      int earlyErrs;
      int donePulses;

      vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{OP_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
      vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
      vecs[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[7]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
      vecs[8]  = '{OP_MULT,  32'hFFFFFFFB, 32'hFFFFFFF9, 32'd0,        32'd35};
      vecs[9]  = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
      vecs[10] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0};
      vecs[11] = '{OP_DIV,   32'hFFFFFFF8, 32'd3,        32'hFFFFFFFE, 32'hFFFFFFFE};
      vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
      vecs[13] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0};

      Reset   = 1'b1;
      start   = 1'b0;
      op      = 2'b00;
      a       = '0;
      b       = '0;
      rd_hilo = 1'b0;
      wr_hi   = 1'b0;
      wr_lo   = 1'b0;
      wdata   = '0;

      repeat (3) @(negedge Clk);
      checkOutput("reset hi", hi, 0);
      checkOutput("reset lo", lo, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset done", done, 0);
      checkOutput("reset stall", stall, 0);
      Reset = 1'b0;

      for (int i = 0; i < NUM_VECS; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         checkOutput($sformatf("vec%0d latency", i), lat, 35);
         checkOutput($sformatf("vec%0d hi", i), hi, vecs[i].expHi);
         checkOutput($sformatf("vec%0d lo", i), lo, vecs[i].expLo);
         checkOutput($sformatf("vec%0d busy at done", i), busy, 0);
      end

      // MTHI in IDLE: hi changes next cycle, lo keeps the last result (0).
      @(negedge Clk);
      wr_hi = 1'b1;
      wdata = 32'h12345678;
      @(negedge Clk);
      wr_hi = 1'b0;
      checkOutput("mthi hi", hi, 32'h12345678);
      checkOutput("mthi lo", lo, 0);

      // MFHI arrives in cycle 5 of a divide and is held until released.
      @(negedge Clk);
      start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
      errs = 0; earlyErrs = 0;
      for (int c = 1; c <= 35; c++) begin
         @(negedge Clk);
         start = 1'b0;
         if (c == 5) rd_hilo = 1'b1;
         #1;
         if (c < 5 && stall !== 1'b0) earlyErrs++;
         if (c >= 5 && c <= 34 && stall !== 1'b1) errs++;
         if (c == 35) begin
            checkOutput("mfhi stall released", stall, 0);
            checkOutput("mfhi done", done, 1);
            checkOutput("mfhi hi", hi, 32'd2);
            checkOutput("mfhi lo", lo, 32'd14);
         end
      end
      checkOutput("unrelated no stall", earlyErrs, 0);
      checkOutput("mfhi stall window", errs, 0);
      @(negedge Clk);
      rd_hilo = 1'b0;

      // Second start in cycle 10 is stalled, then accepted in cycle 35.
      @(negedge Clk);
      start = 1'b1; op = OP_MULTU; a = 32'd6; b = 32'd7;
      errs = 0;
      for (int c = 1; c <= 35; c++) begin
         @(negedge Clk);
         if (c == 1) start = 1'b0;
         if (c == 10) begin
            start = 1'b1; a = 32'd3; b = 32'd5;
         end
         #1;
         if (c >= 10 && c <= 34 && stall !== 1'b1) errs++;
         if (c == 35) begin
            checkOutput("b2b stall released", stall, 0);
            checkOutput("b2b first done", done, 1);
            checkOutput("b2b first lo", lo, 32'd42);
         end
      end
      checkOutput("b2b stall window", errs, 0);
      lat = 0;
      while (lat < 100) begin
         @(negedge Clk);
         lat++;
         start = 1'b0;
         if (done) break;
      end
      checkOutput("b2b second latency", lat, 35);
      checkOutput("b2b second lo", lo, 32'd15);
      checkOutput("b2b second hi", hi, 0);

      // MTLO while busy: stalled, lo holds until the op finishes, then MTLO lands.
      @(negedge Clk);
      start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
      errs = 0;
      for (int c = 1; c <= 35; c++) begin
         @(negedge Clk);
         start = 1'b0;
         if (c == 3) begin
            wr_lo = 1'b1; wdata = 32'h0000ABCD;
         end
         #1;
         if (c >= 3 && c <= 34 && (stall !== 1'b1 || lo !== 32'd15)) errs++;
         if (c == 35) begin
            checkOutput("mtlo busy done", done, 1);
            checkOutput("mtlo busy result lo", lo, 32'd6);
            checkOutput("mtlo busy stall released", stall, 0);
         end
      end
      checkOutput("mtlo busy hold", errs, 0);
      @(negedge Clk);
      wr_lo = 1'b0;
      #1;
      checkOutput("mtlo accepted lo", lo, 32'h0000ABCD);
      checkOutput("mtlo accepted hi", hi, 0);

      // MTHI together with start in IDLE, then reset in cycle 20 of the MULT.
      @(negedge Clk);
      start = 1'b1; op = OP_MULT; a = 32'h1234; b = 32'd5;
      wr_hi = 1'b1; wdata = 32'h5555AAAA;
      for (int c = 1; c <= 20; c++) begin
         @(negedge Clk);
         start = 1'b0;
         wr_hi = 1'b0;
         if (c == 1) begin
            checkOutput("start+mthi hi", hi, 32'h5555AAAA);
            checkOutput("start+mthi busy", busy, 1);
         end
         if (c == 20) Reset = 1'b1;
      end
      @(negedge Clk);
      Reset = 1'b0;
      checkOutput("midop reset busy", busy, 0);
      checkOutput("midop reset hi", hi, 0);
      checkOutput("midop reset lo", lo, 0);
      checkOutput("midop reset done", done, 0);
      donePulses = 0;
      repeat (40) begin
         @(negedge Clk);
         if (done) donePulses++;
      end
      checkOutput("midop reset no done", donePulses, 0);
      applyStimulus(OP_MULTU, 32'd3, 32'd4, lat);
      checkOutput("post reset latency", lat, 35);
      checkOutput("post reset lo", lo, 32'd12);
      checkOutput("post reset hi", hi, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
